// File: rtl/final_adder_pkg.sv
// Shared widths, types and result-register states for the final adder arbiter.
// Imported by the arbiter top and its sub-modules.
package final_adder_pkg;
    localparam int W     = 10;
    localparam int N_REQ = 2;
    localparam int ID_W  = $clog2(N_REQ);

    typedef logic [W-1:0]    word_t;
    typedef logic [ID_W-1:0] id_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;
endpackage

// File: rtl/final_adder.sv
// Carry-propagate stage of the Wallace 5x5 multiplier: sum = (a + b) mod 2^W.
// Ports: a, b operands; sum result, carry-out discarded.
module final_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/final_adder_arb_rr_pick.sv
// Round-robin priority search: first set req_valid bit at or after ptr.
// Ports: req_valid, ptr in; gnt winning index, any = some request valid.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt,
    output logic             any
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[idx[ID_W-1:0]]) begin
                gnt = idx[ID_W-1:0];
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/final_adder_arb.sv
// Round-robin share of one final_adder among N_REQ requesters; registered sum
// and requester id on a valid/ready response channel.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b per requester (flattened);
// rsp_valid/rsp_ready/rsp_id/rsp_sum response.
module final_adder_arb
    import final_adder_pkg::*;
#(
    parameter int W     = final_adder_pkg::W,
    parameter int N_REQ = final_adder_pkg::N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_sum
);
    rsp_state_t      state, state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic            any;
    logic            slot_free;
    logic            accept;
    logic [W-1:0]    a_arr [N_REQ];
    logic [W-1:0]    b_arr [N_REQ];
    logic [W-1:0]    add_sum;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .gnt       (gnt),
        .any       (any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = req_a[i*W +: W];
            b_arr[i] = req_b[i*W +: W];
        end
    end

    final_adder #(
        .W (W)
    ) u_add (
        .a   (a_arr[gnt]),
        .b   (b_arr[gnt]),
        .sum (add_sum)
    );

    assign rsp_valid = (state == FULL);
    assign slot_free = !rsp_valid || rsp_ready;
    // any implies req_valid[gnt], so a grant with a free slot is an accept.
    assign accept    = any && slot_free;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        if (accept)         state_nx = FULL;
        else if (rsp_ready) state_nx = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            rsp_sum <= '0;
            rsp_id  <= '0;
            ptr     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rsp_sum <= add_sum;
                rsp_id  <= gnt;
                ptr     <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/final_adder_arb.md
# final_adder_arb

Round-robin arbiter that shares one `final_adder` instance (the 10-bit carry-propagate stage of the Wallace 5x5 multiplier) between `N_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one requester per cycle, muxes its operands into the adder and registers the sum. It returns the sum with the requester's ID on a single valid/ready response channel. The block sits between the Wallace reduction stages of several multiplier lanes and the shared final adder.

## Interface
- `W`, 10: operand and sum width, matching `final_adder`.
- `N_REQ`, 2: number of requesters, range 2..8.
- `ID_W`, `$clog2(N_REQ)`: response ID width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  N_REQ×W  operand A per requester.
- `req_b`  in  N_REQ×W  operand B per requester.
- `rsp_valid`  out  1  result register holds a valid sum.
- `rsp_ready`  in  1  downstream consumes the result.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_sum`.
- `rsp_sum`  out  W  `(a + b) mod 2^W`.

## Operation
- Result register states:
  - EMPTY: `rsp_valid=0`.
  - FULL: `rsp_valid=1`.
- `slot_free = !rsp_valid || rsp_ready`.
- Arbitration (combinational):
  - Search `req_valid` starting at index `ptr`, wrapping modulo `N_REQ`.
  - The first set bit wins and becomes `gnt`.
  - `req_ready[gnt] = slot_free`. All other `req_ready` bits are 0.
  - If no `req_valid` bit is set, all `req_ready` are 0.
- Accept event: `req_valid[gnt] && req_ready[gnt]`. On accept:
  - Capture the `final_adder` output for `req_a[gnt]`, `req_b[gnt]` into `rsp_sum`.
  - Capture `gnt` into `rsp_id`.
  - Set `rsp_valid=1`.
  - Set `ptr <= (gnt+1) mod N_REQ`.
- Ready without valid:
  - If `rsp_ready` is high and there is no accept, set `rsp_valid <= 0`.
  - Otherwise the state holds.
- FULL with `rsp_ready=0`:
  - All `req_ready` are 0.
  - `rsp_sum` and `rsp_id` stay stable. They must not change while `rsp_valid && !rsp_ready`.
- Simultaneous consume and accept: when `rsp_ready` and an accept occur in the same cycle, the register reloads with the new result and `rsp_valid` stays 1. Back-to-back throughput is 1 result per cycle.
- Arithmetic:
  - The sum is W bits and the carry-out is discarded, matching `final_adder`.
  - Example: 1023 + 1023 gives 1022.
- Fairness: with all requesters continuously valid and `rsp_ready=1`, grants rotate 0, 1, …, N_REQ-1, 0, …
- A requester must hold `req_a`, `req_b` and `req_valid` stable until accepted. The arbiter does not check this.

## Timing
- Reset values (asynchronous, immediate on `rst_n=0`):
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `ptr=0`.
  - `req_ready` evaluates to the combinational function of these and the inputs.
- Reset mid-operation: any held result is dropped without handshake, and `ptr` returns to 0.
- First grant after reset release goes to the lowest-index valid requester.
- Latency: accept at rising edge t gives `rsp_valid=1` with the sum after edge t (visible in cycle t+1).
- `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. There is no path from `req_a`/`req_b` to `req_ready`.
- Critical path: operand mux, then `final_adder`, then `rsp_sum` register. The path must close in one cycle.

## Structure
- Package `final_adder_pkg` holds:
  - `W`
  - `N_REQ`
  - `ID_W`
  - `typedef logic [W-1:0] word_t`
  - `typedef logic [ID_W-1:0] id_t`
- Sub-modules:
  - `final_adder` is instantiated once, unmodified, on the muxed operands.
  - The round-robin priority search is a natural sub-module, `rr_pick`. Its inputs are `req_valid` and `ptr`. Its outputs are `gnt` and `any`.

## Test plan
- Single request: requester 0 sends a=429, b=339 with `rsp_ready=1` → `req_ready[0]=1` the same cycle; next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_sum=768`.
- Overflow wrap: requester 1 sends a=1023, b=1023 → `rsp_sum=1022`, `rsp_id=1`.
- Contention: both requesters valid continuously, `rsp_ready=1`, after reset → `rsp_id` sequence 0,1,0,1 with 1 result per cycle; each sum is correct for its requester's operands.
- Backpressure: hold `rsp_ready=0` for 3 cycles while both requesters are valid →
  - all `req_ready=0`;
  - `rsp_sum` and `rsp_id` stable;
  - on release, the held result is consumed and the next requester is accepted in the same cycle.
- Reset mid-operation: assert `rst_n=0` while `rsp_valid=1` → `rsp_valid`, `rsp_sum`, `rsp_id` go to 0 immediately; after release with both requesters valid, the first grant is to requester 0.
- Idle: no `req_valid` for 5 cycles with `rsp_ready=1` → `rsp_valid` falls to 0 after the pending result is consumed, and `ptr` is unchanged.
